// File: rtl/addsub_calc.sv
// addsub_calc: switch-entry add/subtract calculator with a decimal seven-segment display.
//
// Operands A and B are loaded from the switches while the display selects
// them and the calculator is not read-only. The value shown (A, B or the
// result) goes through a serial double-dabble converter. The converter
// updates the digit register only when a conversion completes, so the
// previous digits stay on seg until then.
//
// Optional feature: define CALC_SUB_EN to enable subtract mode. In that
// build, a btn3 press while the display already shows S toggles add/sub.
//
// Parameters:
//   W      operand width in bits (>= 2)
//   DIGITS number of decimal display digits (must cover 2^(W+1)-1)
//   DB_N   debounce stability window, in clk cycles
//
// Ports:
//   clk    single clock; all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   sws    operand entry switches
//   btns   raw push buttons, active-high and bouncing
//          btn0 readonly toggle, btn1 show A, btn2 show B, btn3 show S
//   seg    seven-segment patterns; digit 0 (units) in [7:0], gfedcba, bit 7 = 0
//   leds   {readonly, neg, carry, 2'b00, display[2:0]}
//   busy   high while a BCD conversion is in progress
module addsub_calc #(
  parameter int W      = 8,
  parameter int DIGITS = 3,
  parameter int DB_N   = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        sws,
  input  logic [3:0]          btns,
  output logic [DIGITS*8-1:0] seg,
  output logic [7:0]          leds,
  output logic                busy
);

  localparam int CNT_W  = (DB_N > 1) ? $clog2(DB_N) : 1;
  localparam int STEP_W = $clog2(W + 1);
  localparam int BCD_W  = DIGITS * 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } conv_state_t;

  typedef enum logic [2:0] {
    DISP_A = 3'b001,
    DISP_B = 3'b010,
    DISP_S = 3'b100
  } disp_t;

  // ---------------------------------------------------------------------------
  // Button synchroniser, debouncer and press detection
  // ---------------------------------------------------------------------------
  logic [3:0]            btn_sync;
  logic [3:0]            btn_db;
  logic [3:0]            btn_last;
  logic [3:0][CNT_W-1:0] db_cnt;
  logic [3:0]            press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      btn_db   <= '0;
      btn_last <= '0;
      db_cnt   <= '0;
    end else begin
      btn_sync <= btns;
      btn_last <= btn_db;
      for (int unsigned i = 0; i < 4; i++) begin
        // The counter measures how long the synchronised input has
        // disagreed with the debounced output; any agreement restarts it.
        if (btn_sync[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DB_N - 1)) begin
          btn_db[i] <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = btn_db & ~btn_last;

  // ---------------------------------------------------------------------------
  // Control state: readonly flag and display selection
  // ---------------------------------------------------------------------------
  logic  readonly;
  disp_t display;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readonly <= 1'b0;
      display  <= DISP_A;
    end else begin
      if (press[0]) begin
        readonly <= ~readonly;
      end
      if (press[1]) begin
        display <= DISP_A;
      end else if (press[2]) begin
        display <= DISP_B;
      end else if (press[3]) begin
        display <= DISP_S;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand registers
  // ---------------------------------------------------------------------------
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (!readonly) begin
      if (display == DISP_A) begin
        a_reg <= sws;
      end else if (display == DISP_B) begin
        b_reg <= sws;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  logic [W:0] result;
  logic       carry;
  logic       neg;

`ifdef CALC_SUB_EN
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  op_t op;

  // A btn1/btn2 press in the same cycle wins over btn3, so it blocks the toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= OP_ADD;
    end else if (press[3] && !press[1] && !press[2] && display == DISP_S) begin
      op <= (op == OP_ADD) ? OP_SUB : OP_ADD;
    end
  end

  always_comb begin
    result = '0;
    carry  = 1'b0;
    neg    = 1'b0;
    if (op == OP_SUB) begin
      if (a_reg < b_reg) begin
        result = {1'b0, b_reg - a_reg};
        neg    = 1'b1;
      end else begin
        result = {1'b0, a_reg - b_reg};
      end
    end else begin
      result = {1'b0, a_reg} + {1'b0, b_reg};
      carry  = result[W];
    end
  end
`else
  always_comb begin
    result = {1'b0, a_reg} + {1'b0, b_reg};
    carry  = result[W];
  end

  assign neg = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Value selected for display
  // ---------------------------------------------------------------------------
  logic [W:0] shown;

  always_comb begin
    shown = result;
    case (display)
      DISP_A:  shown = {1'b0, a_reg};
      DISP_B:  shown = {1'b0, b_reg};
      default: shown = result;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Binary-to-BCD conversion (serial double dabble)
  // ---------------------------------------------------------------------------
  conv_state_t       state_q;
  conv_state_t       state_d;
  logic [W:0]        conv_src;
  logic [W:0]        bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [STEP_W-1:0] step_q;
  logic [BCD_W-1:0]  digits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (shown != conv_src) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (step_q == STEP_W'(W)) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        busy    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Add 3 to every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_src <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      digits_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (shown != conv_src) begin
            conv_src <= shown;
            bin_q    <= shown;
            bcd_q    <= '0;
            step_q   <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[W]};
          bin_q  <= {bin_q[W-1:0], 1'b0};
          step_q <= step_q + STEP_W'(1);
        end
        ST_LATCH: begin
          digits_q <= bcd_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Seven-segment decode with leading-zero blanking
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic       lead;
  logic [3:0] nib;

  // Scan from the most significant digit down; blanking stops at the first
  // nonzero digit, and the units digit is always shown.
  always_comb begin
    seg  = '0;
    lead = 1'b1;
    nib  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = digits_q[(DIGITS-1-i)*4 +: 4];
      if (nib != 4'd0 || i == DIGITS - 1) begin
        lead = 1'b0;
      end
      if (!lead) begin
        seg[(DIGITS-1-i)*8 +: 8] = {1'b0, seg7(nib)};
      end
    end
  end

  assign leds = {readonly, neg, carry, 2'b00, display};

endmodule
